fib_seq_gen: RTL
================

# fib_seq_gen

Streaming Fibonacci sequence generator built on the team's 8-bit register, mux and toggle primitives. On a start request it emits terms F(0), F(1), … F(n−1) one per handshake over a valid/ready output port. It feeds the downstream display/consumer stage, and it flags terms that exceed the data width.

## Interface
- `WIDTH`, default 8: term width in bits.
- `CNT_W`, default 5: width of the term-count request (up to 2^CNT_W−1 terms).

Ports (clock and reset first):
- `clk` — in, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` — in, 1 bit: asynchronous, active-low reset.
- `start` — in, 1 bit: sequence request; sampled only in IDLE.
- `n_terms` — in, CNT_W bits: number of terms to emit; sampled with `start`.
- `out_valid` — out, 1 bit: a term is presented.
- `out_ready` — in, 1 bit: consumer accepts the term.
- `out_data` — out, WIDTH bits: current term, truncated or saturated.
- `out_last` — out, 1 bit: the current term is the final one of the sequence.
- `out_ovf` — out, 1 bit: the true value of the current term is ≥ 2^WIDTH.
- `busy` — out, 1 bit: high in RUN.
- `done` — out, 1 bit: one-cycle pulse after the last handshake.
- `overflow` — out, 1 bit: sticky flag; an overflowed term was emitted.

## Operation
- Registers:
  - `a` and `b`, WIDTH bits each, with shadow bits `a_ovf` and `b_ovf`.
  - `rem`, CNT_W bits: remaining terms.
  - `state`: IDLE or RUN.
- Handshake occurs when `out_valid` and `out_ready` are both high.
- IDLE:
  - `start`=1 with `n_terms`≠0: load a=0, b=1, a_ovf=b_ovf=0, rem=`n_terms`; clear `overflow`; go to RUN.
  - `start` with `n_terms`=0 is ignored. IDLE is held and `overflow` is not cleared.
- RUN:
  - `out_valid`=1, `out_data`=a, `out_ovf`=a_ovf, `out_last`=(rem==1).
  - On a handshake:
    - a←b and a_ovf←b_ovf.
    - b←sum(a,b) (rule below) and b_ovf←carry | a_ovf | b_ovf.
    - rem←rem−1.
    - If `out_ovf`=1, set `overflow`.
    - If rem was 1, go to IDLE and pulse `done` in the next cycle.
  - Without a handshake, all registers hold. `out_data`, `out_ovf` and `out_last` stay stable while stalled.
- `start` in RUN is ignored and does not queue.
- Sum: the (WIDTH+1)-bit sum a+b. The carry is bit WIDTH; the result per Configuration.
- `busy` = (state==RUN). `out_valid` = `busy`.

## Timing
- Reset (asynchronous assertion): state=IDLE, a=0, b=0, rem=0. Outputs: `out_valid`=0, `out_data`=0, `out_last`=0, `out_ovf`=0, `busy`=0, `done`=0, `overflow`=0. Reset takes effect immediately, including mid-sequence; the partial sequence is discarded.
- Latency: `start` accepted at edge k → `out_valid`=1 with F(0)=0 from edge k+1.
- With `out_ready` held at 1: one term per cycle; n terms occupy n cycles.
- After the last handshake at edge m: `busy`=0 and `done`=1 for the cycle after m. A new `start` can be accepted at edge m+1. There is a minimum of one idle cycle between sequences.
- `done` is high for exactly one cycle and is never asserted without a prior RUN.
- Outputs are registered or decoded directly from registers; no combinational path from `out_ready` to `out_valid`.

## Configuration
- `FIB_SEQ_GEN_SAT_EN` defined: b←all-ones when carry=1 or b_ovf=1. Overflowed terms are emitted as 2^WIDTH−1.
- Not defined: b←(a+b) mod 2^WIDTH, i.e. wrap-around.
- `out_ovf`, `overflow` and the shadow-bit logic are identical in both builds.

## Test plan
- **Basic sequence:** `n_terms`=10, `out_ready`=1.
  - Data 0,1,1,2,3,5,8,13,21,34 on 10 consecutive cycles.
  - `out_last` only on 34; `done` the cycle after; `overflow`=0.
- **Backpressure:** `n_terms`=6, `out_ready` toggling 1/0 each cycle.
  - Data 0,1,1,2,3,5, each held unchanged through stall cycles.
  - 6 handshakes total.
- **Overflow, WIDTH=8:** `n_terms`=15.
  - Beats 1–14 end at 233 with `out_ovf`=0.
  - Beat 15 shows 121 (wrap) or 255 (`FIB_SEQ_GEN_SAT_EN`) with `out_ovf`=1.
  - `overflow`=1 after that beat; cleared by the next accepted `start`.
- **Single term and ignored starts:** `n_terms`=1.
  - One beat, data 0, `out_last`=1, then `done`.
  - `start` with `n_terms`=0 → `busy` stays 0.
  - `start` pulsed mid-RUN → no effect on the sequence.
- **Reset mid-sequence:** assert `rst_n`=0 after 5 handshakes of a 10-term run.
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, `start` with `n_terms`=3 → 0,1,1.
- **Back-to-back:** `start` held high with `n_terms`=3.
  - Emits 0,1,1, then one idle cycle with `done`=1, then 0,1,1 again.

Source files
------------

// File: rtl/fib_seq_gen.sv
// Streaming Fibonacci generator: emits F(0)..F(n-1) over valid/ready, flags terms >= 2^WIDTH.
// Latency: start accepted at edge k -> F(0) valid from edge k+1; one term per handshake.
// Backpressure: all state holds while out_ready=0; FIB_SEQ_GEN_SAT_EN saturates instead of wrapping.
module fib_seq_gen #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] n_terms,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             out_ovf,
   output logic             busy,
   output logic             done,
   output logic             overflow
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               a_ovf_q, a_ovf_d;
   logic               b_ovf_q, b_ovf_d;
   logic [CNT_W-1:0]   rem_q, rem_d;
   logic               done_q, done_d;
   logic               overflow_q, overflow_d;

   logic               hs;
   logic               last_beat;
   logic [WIDTH:0]     sum;
   logic               carry;
   logic [WIDTH-1:0]   sum_res;

   assign sum       = {1'b0, a_q} + {1'b0, b_q};
   assign carry     = sum[WIDTH];
   assign last_beat = (rem_q == CNT_W'(1));

`ifdef FIB_SEQ_GEN_SAT_EN
   // Once the true value has left the representable range it stays pinned at all-ones.
   assign sum_res = (carry | b_ovf_q) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
   assign sum_res = sum[WIDTH-1:0];
`endif

   assign busy      = (state_q == RUN);
   assign out_valid = busy;
   assign out_data  = busy ? a_q : '0;
   assign out_ovf   = busy & a_ovf_q;
   assign out_last  = busy & last_beat;
   assign done      = done_q;
   assign overflow  = overflow_q;
   assign hs        = out_valid & out_ready;

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      a_ovf_d    = a_ovf_q;
      b_ovf_d    = b_ovf_q;
      rem_d      = rem_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && (n_terms != '0)) begin
               a_d        = '0;
               b_d        = WIDTH'(1);
               a_ovf_d    = 1'b0;
               b_ovf_d    = 1'b0;
               rem_d      = n_terms;
               overflow_d = 1'b0;
               state_d    = RUN;
            end
         end
         RUN: begin
            if (hs) begin
               a_d     = b_q;
               a_ovf_d = b_ovf_q;
               b_d     = sum_res;
               b_ovf_d = carry | a_ovf_q | b_ovf_q;
               rem_d   = rem_q - CNT_W'(1);
               if (a_ovf_q) begin
                  overflow_d = 1'b1;
               end
               if (last_beat) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         a_ovf_q    <= 1'b0;
         b_ovf_q    <= 1'b0;
         rem_q      <= '0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         a_ovf_q    <= a_ovf_d;
         b_ovf_q    <= b_ovf_d;
         rem_q      <= rem_d;
         done_q     <= done_d;
         overflow_q <= overflow_d;
      end
   end

endmodule
